fifo_rr_sched: RTL

Round-robin pop scheduler for the 10-bit FIFO bank. It sits between `N_QUEUES` input FIFOs and one downstream output FIFO.
- It programs the almost-full/almost-empty thresholds of every FIFO during an init phase.
- It then drains non-empty input FIFOs one word per cycle, in round-robin order, into the output FIFO.
- It stalls whenever the output FIFO reports almost-full.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_rr_sched_if.sv | 28 ++
 rtl/fifo_rr_sched_rr_arbiter.sv | 28 ++
 rtl/fifo_rr_sched.sv | 116 +++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO bank schedulers: defaults and FSM encodings.
package fifo_pkg;

    localparam int unsigned DEF_N_QUEUES = 4;
    localparam int unsigned DEF_DATA_W   = 10;
    localparam int unsigned DEF_UMB_W    = 3;
    localparam int unsigned STATE_W      = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 3'b001,
        ST_INIT   = 3'b010,
        ST_IDLE   = 3'b011,
        ST_ACTIVE = 3'b100
    } state_e;

endpackage

// File: rtl/fifo_rr_sched_if.sv
// Bus between the scheduler, the input FIFOs (pop side) and the output FIFO (push side).
interface fifo_rr_sched_if
    import fifo_pkg::*;
#(
    parameter int unsigned N_QUEUES = DEF_N_QUEUES,
    parameter int unsigned DATA_W   = DEF_DATA_W
);

    logic [N_QUEUES-1:0]        fifo_empty;
    logic [N_QUEUES*DATA_W-1:0] fifo_data;
    logic [N_QUEUES-1:0]        fifo_pop;
    logic                       out_alm_full;
    logic                       out_push;
    logic [DATA_W-1:0]          out_data;

    // Scheduler side
    modport master (
        input  fifo_empty, fifo_data, out_alm_full,
        output fifo_pop, out_push, out_data
    );

    // FIFO bank side
    modport slave (
        output fifo_empty, fifo_data, out_alm_full,
        input  fifo_pop, out_push, out_data
    );

endinterface

// File: rtl/fifo_rr_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo N.
module rr_arbiter
    import fifo_pkg::*;
#(
    parameter  int unsigned N     = DEF_N_QUEUES,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt_c,
    output logic [IDX_W-1:0] gnt_idx_c,
    output logic             gnt_vld_c
);

    // Scan last+1 .. last+N; the first hit wins and later hits are ignored.
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_idx_c = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            if (!gnt_vld_c && req[(32'(last) + k) % N]) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = IDX_W'((32'(last) + k) % N);
            end
        end
        gnt_c = gnt_vld_c ? (N'(1) << gnt_idx_c) : '0;
    end

endmodule

// File: rtl/fifo_rr_sched.sv
// Round-robin pop scheduler: programs FIFO thresholds, then drains input FIFOs into the output FIFO.
module fifo_rr_sched
    import fifo_pkg::*;
#(
    parameter int unsigned N_QUEUES = DEF_N_QUEUES,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned UMB_W    = DEF_UMB_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic [UMB_W-1:0]     umbral_alto_in,
    input  logic [UMB_W-1:0]     umbral_bajo_in,
    fifo_rr_sched_if.master      bus,
    output logic [UMB_W-1:0]     umbral_alto,
    output logic [UMB_W-1:0]     umbral_bajo,
    output logic [STATE_W-1:0]   state,
    output logic                 idle
);

    localparam int unsigned IDX_W = $clog2(N_QUEUES);

    state_e             state_q, state_d;
    logic               idle_q, idle_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               out_push_q, out_push_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [UMB_W-1:0]   alto_q, alto_d;
    logic [UMB_W-1:0]   bajo_q, bajo_d;

    logic [N_QUEUES-1:0] req_c;
    logic [N_QUEUES-1:0] arb_gnt_c;
    logic [IDX_W-1:0]    arb_idx_c;
    logic                arb_vld_c;
    logic                grant_c;
    logic                any_req_c;

    assign req_c     = ~bus.fifo_empty;
    assign any_req_c = |req_c;

    rr_arbiter #(
        .N         (N_QUEUES)
    ) u_arb (
        .req       (req_c),
        .last      (last_q),
        .gnt_c     (arb_gnt_c),
        .gnt_idx_c (arb_idx_c),
        .gnt_vld_c (arb_vld_c)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESET;
            idle_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
        end
    end

    // Next-state logic; init always takes priority over draining
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE: begin
                if (init)           state_d = ST_INIT;
                else if (any_req_c) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)                           state_d = ST_INIT;
                else if (!any_req_c && !out_push_q) state_d = ST_IDLE;
            end
            default:   state_d = ST_RESET;
        endcase
    end

    // Grant, push path, pointer and threshold next values
    always_comb begin
        grant_c      = (state_q == ST_ACTIVE) && !bus.out_alm_full && !init && arb_vld_c;
        bus.fifo_pop = grant_c ? arb_gnt_c : '0;
        last_d       = grant_c ? arb_idx_c : last_q;
        out_push_d   = grant_c;
        out_data_d   = grant_c ? bus.fifo_data[32'(arb_idx_c) * DATA_W +: DATA_W] : '0;
        alto_d       = (state_q == ST_INIT) ? umbral_alto_in : alto_q;
        bajo_d       = (state_q == ST_INIT) ? umbral_bajo_in : bajo_q;
        idle_d       = (state_d == ST_IDLE);
    end

    // Datapath registers; the round-robin pointer resets so queue 0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= IDX_W'(N_QUEUES - 1);
            out_push_q <= 1'b0;
            out_data_q <= '0;
            alto_q     <= '0;
            bajo_q     <= '0;
        end else begin
            last_q     <= last_d;
            out_push_q <= out_push_d;
            out_data_q <= out_data_d;
            alto_q     <= alto_d;
            bajo_q     <= bajo_d;
        end
    end

    assign bus.out_push = out_push_q;
    assign bus.out_data = out_data_q;
    assign umbral_alto  = alto_q;
    assign umbral_bajo  = bajo_q;
    assign state        = state_q;
    assign idle         = idle_q;

endmodule
